// File: rtl/ds_arb_rr_pkg.sv
// ds_pkg: shared types and helpers for the ds_* stream blocks.
//   t_arb_st  - arbiter lock state (free arbitration / burst owner)
//   t_rr_res  - result of a round-robin search (found flag + index)
//   rr_next() - round-robin search over a request vector, starting one
//               past the last-served pointer and wrapping at n-1 -> 0
package ds_pkg;

  localparam int unsigned RR_MAXREQ = 32;
  localparam int unsigned RR_IDXW   = 5;

  typedef enum logic {
    ARB_ST_ARB,
    ARB_ST_OWN
  } t_arb_st;

  typedef struct packed {
    logic               found;
    logic [RR_IDXW-1:0] idx;
  } t_rr_res;

  // req: one bit per requester (bit i = requester i wants service).
  // n:   number of requesters actually in use (2..RR_MAXREQ).
  // ptr: index served last; the search begins at ptr+1.
  function automatic t_rr_res rr_next(input logic [RR_MAXREQ-1:0] req,
                                      input int unsigned n,
                                      input int unsigned ptr);
    t_rr_res     r;
    int unsigned c;
    r = '0;
    for (int unsigned k = 1; k <= RR_MAXREQ; k++) begin
      if (k <= n) begin
        c = ptr + k;
        if (c >= n) c = c - n;
        if (!r.found && req[c]) begin
          r.found = 1'b1;
          r.idx   = RR_IDXW'(c);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ds_arb_rr_if.sv
// ds_if: valid/ready stream with a payload of type DTYPE.
//   vld  - producer has a beat
//   rdy  - consumer accepts a beat
//   data - payload
//   xfer - vld && rdy, a beat moves this cycle
// Modports: mst (producer side), slv (consumer side).
interface ds_if #(
  parameter type DTYPE = logic [7:0]
) ();

  logic vld;
  logic rdy;
  DTYPE data;
  logic xfer;

  assign xfer = vld & rdy;

  modport mst (output vld, output data, input rdy, input xfer);
  modport slv (input vld, input data, input xfer, output rdy);

endinterface

// File: rtl/ds_arb_rr_sel.sv
// ds_arb_rr_sel: combinational round-robin selector.
//   req_i - request vector, one bit per requester
//   ptr_i - index of the requester served last
//   gnt_o - one-hot grant (all zeros when nobody requests)
//   idx_o - index of the granted requester (0 when nobody requests)
module ds_arb_rr_sel
  import ds_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o
);

  localparam int unsigned IW = $clog2(NUM_REQ);

  logic [RR_MAXREQ-1:0] req_ext;
  t_rr_res              res;

  always_comb begin
    req_ext                = '0;
    req_ext[NUM_REQ-1:0]   = req_i;
    res                    = rr_next(req_ext, NUM_REQ, 32'(ptr_i));
    idx_o                  = IW'(res.idx);
    gnt_o                  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      gnt_o[i] = res.found && (res.idx == RR_IDXW'(i));
    end
  end

endmodule

// File: rtl/ds_arb_rr.sv
// ds_arb_rr: round-robin arbiter sharing one ds_if output between NUM_REQ
// requesters, with optional burst locking and a one-entry output register.
//   i_clk, i_rst - clock, asynchronous active-high reset
//   if_req[]     - requester streams (slv)
//   if_out       - arbitrated output stream (mst), registered
//   o_src        - source index of the beat held in the output register
//   o_own        - one-hot lock owner, all zeros while arbitrating freely
module ds_arb_rr
  import ds_pkg::*;
#(
  parameter type         DTYPE   = logic [7:0],
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned BURST   = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  ds_if.slv                          if_req [NUM_REQ],
  ds_if.mst                          if_out,
  output logic [$clog2(NUM_REQ)-1:0] o_src,
  output logic [NUM_REQ-1:0]         o_own
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(BURST + 1);

  t_arb_st             st_q;
  logic [IW-1:0]       ptr_q;
  logic [IW-1:0]       oidx_q;
  logic [NUM_REQ-1:0]  own_q;
  logic [CW-1:0]       cnt_q;
  logic                out_vld_q;
  DTYPE                out_data_q;
  logic [IW-1:0]       src_q;

  logic [NUM_REQ-1:0]  req_vld;
  DTYPE                req_data [NUM_REQ];
  logic [NUM_REQ-1:0]  rr_gnt;
  logic [IW-1:0]       rr_idx;
  logic [NUM_REQ-1:0]  sel;
  logic [IW-1:0]       sel_idx;
  logic                acc;
  logic                in_xfer;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign req_vld[g]    = if_req[g].vld;
    assign req_data[g]   = if_req[g].data;
    assign if_req[g].rdy = sel[g] & acc;
  end

  ds_arb_rr_sel #(
    .NUM_REQ (NUM_REQ)
  ) u_sel (
    .req_i (req_vld),
    .ptr_i (ptr_q),
    .gnt_o (rr_gnt),
    .idx_o (rr_idx)
  );

  // While locked, the owner is selected whether or not it is valid, so a
  // stall or a missing beat never hands the slot to anyone else.
  assign sel     = (st_q == ARB_ST_OWN) ? own_q  : rr_gnt;
  assign sel_idx = (st_q == ARB_ST_OWN) ? oidx_q : rr_idx;
  assign acc     = !out_vld_q || if_out.rdy;
  assign in_xfer = |(req_vld & sel) && acc;

  assign if_out.vld  = out_vld_q;
  assign if_out.data = out_data_q;
  assign o_src       = src_q;
  assign o_own       = own_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      st_q   <= ARB_ST_ARB;
      ptr_q  <= IW'(NUM_REQ - 1);
      oidx_q <= '0;
      own_q  <= '0;
      cnt_q  <= '0;
    end else begin
      case (st_q)
        ARB_ST_ARB: begin
          if (in_xfer) begin
            if (BURST == 1) begin
              ptr_q <= rr_idx;
            end else begin
              st_q   <= ARB_ST_OWN;
              own_q  <= rr_gnt;
              oidx_q <= rr_idx;
              cnt_q  <= CW'(1);
            end
          end
        end
        ARB_ST_OWN: begin
          if (in_xfer) begin
            // Comparing before the increment: this beat is the last one.
            if (cnt_q == CW'(BURST - 1)) begin
              st_q  <= ARB_ST_ARB;
              ptr_q <= oidx_q;
              own_q <= '0;
              cnt_q <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else if (!req_vld[oidx_q] && acc) begin
            st_q  <= ARB_ST_ARB;
            ptr_q <= oidx_q;
            own_q <= '0;
            cnt_q <= '0;
          end
        end
        default: st_q <= ARB_ST_ARB;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      src_q      <= '0;
    end else if (in_xfer) begin
      out_vld_q  <= 1'b1;
      out_data_q <= req_data[sel_idx];
      src_q      <= sel_idx;
    end else if (if_out.xfer) begin
      out_vld_q  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ds_arb_rr.sv
module tb_ds_arb_rr;

  localparam int NR = 4;
  typedef logic [7:0] dt_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NR-1:0] s_vld;
  dt_t           s_data [NR];
  logic          s_ordy;

  ds_if #(.DTYPE(dt_t)) rq0 [NR] ();
  ds_if #(.DTYPE(dt_t)) rq1 [NR] ();
  ds_if #(.DTYPE(dt_t)) ob0 ();
  ds_if #(.DTYPE(dt_t)) ob1 ();

  logic [NR-1:0] rdy0, rdy1, own0, own1;
  logic [1:0]    src0, src1;

  for (genvar g = 0; g < NR; g++) begin : g_drv
    assign rq0[g].vld  = s_vld[g];
    assign rq0[g].data = s_data[g];
    assign rq1[g].vld  = s_vld[g];
    assign rq1[g].data = s_data[g];
    assign rdy0[g]     = rq0[g].rdy;
    assign rdy1[g]     = rq1[g].rdy;
  end
  assign ob0.rdy = s_ordy;
  assign ob1.rdy = s_ordy;

  ds_arb_rr #(.DTYPE(dt_t), .NUM_REQ(NR), .BURST(1)) u_b1 (
    .i_clk(clk), .i_rst(rst), .if_req(rq0), .if_out(ob0),
    .o_src(src0), .o_own(own0));

  ds_arb_rr #(.DTYPE(dt_t), .NUM_REQ(NR), .BURST(4)) u_b4 (
    .i_clk(clk), .i_rst(rst), .if_req(rq1), .if_out(ob1),
    .o_src(src1), .o_own(own1));

  int n_tot  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
  endtask

  // Reference model: pointer, owner (-1 = none), beat count, and a
  // scoreboard of accepted beats (src*256+data) awaiting the output.
  int          BL [2] = '{1, 4};
  int          m_ptr [2];
  int          m_own [2];
  int          m_cnt [2];
  int          m_sb  [2][$];

  logic        ob_vld  [2];
  logic [1:0]  ob_src  [2];
  dt_t         ob_data [2];
  logic [3:0]  ob_own  [2];
  logic [3:0]  ob_rdy  [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ptr[k] = NR - 1;
      m_own[k] = -1;
      m_cnt[k] = 0;
      m_sb[k].delete();
    end
  endtask

  task automatic model_cycle(input int k);
    bit acc, xin, fnd;
    int g, c, erdy, eown;
    acc = (m_sb[k].size() == 0) || s_ordy;
    g   = -1;
    fnd = 0;
    if (m_own[k] >= 0) g = m_own[k];
    else begin
      for (int j = 1; j <= NR; j++) begin
        c = (m_ptr[k] + j) % NR;
        if (!fnd && s_vld[c]) begin
          g   = c;
          fnd = 1;
        end
      end
    end
    erdy = (g >= 0 && acc) ? (1 << g) : 0;
    eown = (m_own[k] >= 0) ? (1 << m_own[k]) : 0;
    chk($sformatf("d%0d_rdy", k), int'(ob_rdy[k]), erdy);
    chk($sformatf("d%0d_vld", k), int'(ob_vld[k]), int'(m_sb[k].size() != 0));
    if (m_sb[k].size() != 0 && ob_vld[k])
      chk($sformatf("d%0d_beat", k), int'(ob_src[k]) * 256 + int'(ob_data[k]), m_sb[k][0]);
    chk($sformatf("d%0d_own", k), int'(ob_own[k]), eown);

    if (m_sb[k].size() != 0 && s_ordy) void'(m_sb[k].pop_front());
    xin = (g >= 0) && acc && s_vld[g];
    if (xin) m_sb[k].push_back(g * 256 + int'(s_data[g]));
    if (xin) begin
      if (m_own[k] < 0) begin
        if (BL[k] == 1) m_ptr[k] = g;
        else begin
          m_own[k] = g;
          m_cnt[k] = 1;
        end
      end else begin
        m_cnt[k]++;
        if (m_cnt[k] == BL[k]) begin
          m_ptr[k] = m_own[k];
          m_own[k] = -1;
          m_cnt[k] = 0;
        end
      end
    end else if (m_own[k] >= 0 && !s_vld[m_own[k]] && acc) begin
      m_ptr[k] = m_own[k];
      m_own[k] = -1;
      m_cnt[k] = 0;
    end
  endtask

  // Called at a falling edge: drive, sample, check and advance the model,
  // then wait for the next falling edge.
  task automatic step(input logic [NR-1:0] v, input logic ordy);
    s_vld  = v;
    s_ordy = ordy;
    for (int i = 0; i < NR; i++) s_data[i] = 8'($urandom);
    #1;
    ob_vld[0] = ob0.vld;  ob_src[0] = src0; ob_data[0] = ob0.data;
    ob_own[0] = own0;     ob_rdy[0] = rdy0;
    ob_vld[1] = ob1.vld;  ob_src[1] = src1; ob_data[1] = ob1.data;
    ob_own[1] = own1;     ob_rdy[1] = rdy1;
    model_cycle(0);
    model_cycle(1);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst    = 1'b1;
    s_vld  = '0;
    s_ordy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    dt_t        hold_d;
    logic [1:0] hold_s;
    s_vld  = '0;
    s_ordy = 1'b1;
    for (int i = 0; i < NR; i++) s_data[i] = '0;
    model_reset();
    #1;
    chk("rst_vld0", int'(ob0.vld), 0);
    chk("rst_src0", int'(src0), 0);
    chk("rst_own1", int'(own1), 0);
    @(negedge clk);

    // All requesters valid: 0,1,2,3,... per beat / 0x4,1x4 per burst.
    apply_reset();
    for (int k = 1; k <= 9; k++) begin
      step(4'b1111, 1'b1);
      if (k == 1) chk("t1_first_empty", int'(ob_vld[0]), 0);
      else begin
        chk("t1_vld0", int'(ob_vld[0]), 1);
        chk("t1_src0", int'(ob_src[0]), (k - 2) % 4);
        chk("t1_src1", int'(ob_src[1]), ((k - 2) / 4) % 4);
      end
    end

    // Requesters 1 and 2 under bursts of 4.
    apply_reset();
    for (int k = 1; k <= 10; k++) begin
      step(4'b0110, 1'b1);
      if (k >= 2) chk("t2_src1", int'(ob_src[1]), (k <= 5) ? 1 : ((k <= 9) ? 2 : 1));
      if (k == 3) chk("t2_own_a", int'(ob_own[1]), 2);
      if (k == 7) chk("t2_own_b", int'(ob_own[1]), 4);
    end

    // Owner 1 drops after two beats while 3 waits: one bubble, then 3 owns.
    apply_reset();
    for (int k = 1; k <= 6; k++) begin
      step((k <= 2) ? 4'b1010 : 4'b1000, 1'b1);
      if (k == 3) chk("t3_src_b2", int'(ob_src[1]), 1);
      if (k == 4) chk("t3_bubble", int'(ob_vld[1]), 0);
      if (k == 5) begin
        chk("t3_src3", int'(ob_src[1]), 3);
        chk("t3_own3", int'(ob_own[1]), 8);
      end
    end

    // Five stalled cycles with the output register full.
    apply_reset();
    for (int k = 1; k <= 14; k++) begin
      step(4'b1111, (k >= 4 && k <= 8) ? 1'b0 : 1'b1);
      if (k == 4) begin
        hold_d = ob_data[0];
        hold_s = ob_src[0];
      end
      if (k >= 4 && k <= 8) chk("t4_rdy_off", int'(ob_rdy[0]), 0);
      if (k >= 5 && k <= 9) begin
        chk("t4_hold_data", int'(ob_data[0]), int'(hold_d));
        chk("t4_hold_src", int'(ob_src[0]), int'(hold_s));
      end
    end

    // Only requester 3 valid: served every cycle.
    apply_reset();
    for (int k = 1; k <= 6; k++) begin
      step(4'b1000, 1'b1);
      if (k >= 2) begin
        chk("t5_vld", int'(ob_vld[0]), 1);
        chk("t5_src", int'(ob_src[0]), 3);
      end
    end

    // Asynchronous reset in the middle of a burst.
    apply_reset();
    step(4'b1111, 1'b1);
    step(4'b1111, 1'b1);
    #2;
    chk("t6_pre_own", int'(own1), 1);
    rst = 1'b1;
    #1;
    chk("t6_vld1", int'(ob1.vld), 0);
    chk("t6_own1", int'(own1), 0);
    chk("t6_vld0", int'(ob0.vld), 0);
    s_vld = '0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(4'b1111, 1'b1);
    step(4'b1111, 1'b1);
    chk("t6_first0", int'(ob_src[0]), 0);
    chk("t6_first1", int'(ob_src[1]), 0);

    // Randomized traffic with random backpressure.
    apply_reset();
    for (int k = 0; k < 3000; k++) begin
      logic [NR-1:0] v;
      v = NR'($urandom);
      if (k % 1000 >= 500) v = v & NR'($urandom);
      step(v, ($urandom % 4) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
